regfile_wr_sched: RTL
=====================

# regfile_wr_sched

Write-port scheduler for the 32-entry register file. It sweeps every register to zero after reset or on request, then shares the single write port between `NumReq` writeback requesters using round-robin arbitration. It drives the register-file write-enable decoder with a registered `RegWEn`/`WrAddr` pair and supplies the matching write data.

## Interface
- `Width`, 32, register data width
- `NumReq`, 3, number of writeback requesters (2..8)
- `AddrW`, 5, register address width (fixed 5, 32 registers)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `init_req`  in  1  restart the zero sweep
- `hold`  in  1  suppress all grants this cycle
- `req_valid`  in  NumReq  requester has a write pending
- `req_addr`  in  NumReq×AddrW  destination register per requester
- `req_data`  in  NumReq×Width  write data per requester
- `req_ready`  out  NumReq  one-hot grant, combinational
- `RegWEn`  out  1  write enable to decoder, registered
- `WrAddr`  out  AddrW  write address to decoder, registered
- `WrData`  out  Width  write data to register file, registered
- `GrantId`  out  clog2(NumReq)  index of last accepted requester, registered
- `init_done`  out  1  sweep complete, port serving requesters

## Operation
- States: INIT and RUN. Reset enters INIT with sweep counter `cnt`=1.
- INIT:
  - `req_ready` is all 0.
  - Each cycle registers `RegWEn`=1, `WrAddr`=`cnt`, `WrData`=0, then `cnt`++.
  - Register 0 is never written.
  - At the edge that registers address 31, the block moves to RUN and `init_done`←1.
- RUN:
  - A grant is possible only when `hold`=0 and `init_req`=0.
  - Grant goes to the first index i with `req_valid[i]`, scanning cyclically from `rr_ptr`.
  - `req_ready[i]`=1 for the granted index only.
  - A transfer completes when valid and ready are both high.
- On transfer:
  - `WrAddr`←`req_addr[i]`, `WrData`←`req_data[i]`, `GrantId`←i.
  - `RegWEn`←(`req_addr[i]`≠0). Writes to x0 are accepted and dropped.
  - `rr_ptr`←(i+1) mod `NumReq`.
- No transfer: `RegWEn`←0. `WrAddr`, `WrData` and `GrantId` hold their values, and `rr_ptr` holds.
- `init_req`=1 in any state: next state is INIT with `cnt`=1 and `init_done`←0. A sweep already in progress restarts from 1. No grant is issued in that cycle.
- `req_ready` depends on `req_valid` (combinational). Requesters must not derive `req_valid` from `req_ready`.

## Timing
- Reset values: `RegWEn`=0, `WrAddr`=0, `WrData`=0, `GrantId`=0, `init_done`=0, `req_ready`=0, `rr_ptr`=0, state INIT, `cnt`=1.
- Sweep: the first edge after `rst_n` rises registers address 1. Address 31 is registered at the 31st edge. `init_done`=1 from that edge on. The first grant is possible in the following cycle.
- Request latency: `RegWEn`/`WrAddr`/`WrData` appear one cycle after the handshake cycle. Sustained throughput is one write per cycle.
- Fairness:
  - A requester that stays valid is served within `NumReq` grant cycles.
  - With all requesters valid, grants rotate 0,1,2,0,…
  - When `rr_ptr`=`NumReq`−1 and that requester is idle, the scan wraps to 0.
- `hold` and `init_req` both high: `init_req` governs; the effect is identical since neither grants.
- `rst_n` asserted mid-sweep or mid-transfer: outputs clear immediately and asynchronously. The sweep restarts from 1 after release.

## Structure
- Package `regfile_pkg` contains:
  - `REG_ADDR_W`=5
  - `NUM_REGS`=32
  - `typedef enum logic {S_INIT, S_RUN} wr_state_t`
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: one-hot `grant`, encoded `grant_idx`, `any`.
- Top holds the state register, `cnt`, `rr_ptr` and the output registers.

## Test plan
- Reset release, no requests → `RegWEn`=1 for 31 consecutive cycles with `WrAddr`=1..31 and `WrData`=0, then `init_done`=1, `RegWEn`=0.
- After init, requester 1 alone writes addr 7, data 0xDEADBEEF → `req_ready`=3'b010 the same cycle. Next cycle: `RegWEn`=1, `WrAddr`=7, `WrData`=0xDEADBEEF, `GrantId`=1.
- All three valid for 6 cycles → `GrantId` sequence 0,1,2,0,1,2 with one write per cycle.
- Requester 0 writes addr 0 → `req_ready[0]`=1; next cycle `RegWEn`=0; `rr_ptr` advances to 1.
- `hold`=1 with all valid → `req_ready`=0 and `RegWEn`=0 next cycle. Releasing `hold` resumes at the saved `rr_ptr`.
- `init_req` pulsed during RUN, then `rst_n` asserted at sweep address 10 → sweep restarts at 1. On reset, all outputs are 0 immediately; after release the sweep begins at 1 again.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and state type for the register-file write scheduler
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

  typedef enum logic {S_INIT, S_RUN} wr_state_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first valid index at or after rr_ptr
module rr_pick #(
  parameter int NumReq = 3,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_valid,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   grant_idx,
  output logic              any
);

  logic [IdxW-1:0] idx;
  int              sum;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    sum       = 0;
    for (int k = 0; k < NumReq; k++) begin
      // Walk indices cyclically starting at the pointer; first hit wins.
      sum = int'(rr_ptr) + k;
      if (sum >= NumReq) sum = sum - NumReq;
      idx = IdxW'(sum);
      if (!any && req_valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// rtl/regfile_wr_sched.sv - zero-sweep then round-robin sharing of the register-file write port
module regfile_wr_sched
  import regfile_pkg::*;
#(
  parameter int Width  = 32,
  parameter int NumReq = 3,
  parameter int AddrW  = 5,
  localparam int IdxW  = $clog2(NumReq)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            init_req,
  input  logic                            hold,
  input  logic [NumReq-1:0]               req_valid,
  input  logic [NumReq-1:0][AddrW-1:0]    req_addr,
  input  logic [NumReq-1:0][Width-1:0]    req_data,
  output logic [NumReq-1:0]               req_ready,
  output logic                            RegWEn,
  output logic [AddrW-1:0]                WrAddr,
  output logic [Width-1:0]                WrData,
  output logic [IdxW-1:0]                 GrantId,
  output logic                            init_done
);

  wr_state_t              state_q, state_d;
  logic [REG_ADDR_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   reg_wen_q, reg_wen_d;
  logic [AddrW-1:0]       wr_addr_q, wr_addr_d;
  logic [Width-1:0]       wr_data_q, wr_data_d;
  logic [IdxW-1:0]        grant_id_q, grant_id_d;
  logic                   init_done_q, init_done_d;

  logic [NumReq-1:0]      pick_grant;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_any;
  logic                   grant_en;
  logic                   xfer;

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign grant_en  = (state_q == S_RUN) && !hold && !init_req;
  assign req_ready = grant_en ? pick_grant : '0;
  assign xfer      = grant_en && pick_any;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    reg_wen_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    grant_id_d  = grant_id_q;
    init_done_d = init_done_q;

    if (init_req) begin
      state_d     = S_INIT;
      cnt_d       = REG_ADDR_W'(1);
      init_done_d = 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          // x0 is hardwired, so the sweep covers 1..31 only.
          reg_wen_d = 1'b1;
          wr_addr_d = AddrW'(cnt_q);
          wr_data_d = '0;
          cnt_d     = cnt_q + REG_ADDR_W'(1);
          if (cnt_q == LAST_REG) begin
            state_d     = S_RUN;
            init_done_d = 1'b1;
          end
        end
        S_RUN: begin
          if (xfer) begin
            reg_wen_d  = (req_addr[pick_idx] != '0);
            wr_addr_d  = req_addr[pick_idx];
            wr_data_d  = req_data[pick_idx];
            grant_id_d = pick_idx;
            rr_ptr_d   = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + IdxW'(1);
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= REG_ADDR_W'(1);
      rr_ptr_q    <= '0;
      reg_wen_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_id_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      reg_wen_q   <= reg_wen_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      grant_id_q  <= grant_id_d;
      init_done_q <= init_done_d;
    end
  end

  assign RegWEn    = reg_wen_q;
  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  assign GrantId   = grant_id_q;
  assign init_done = init_done_q;

endmodule
